// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-coded serial link (transmitter, receiver, benches).
package rep_code_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int DEFAULT_REPEAT = 5;

    // Clock cycles from the first start chip to the last stop chip, inclusive.
    function automatic int frame_cycles(input int data_w, input int repeat_n, input int clks_per_chip);
        return (data_w + 2) * repeat_n * clks_per_chip;
    endfunction

endpackage

// File: rtl/repetition_code_tx_chip_timer.sv
// Paces one logical bit: CLKS_PER_CHIP clocks per chip, REPEAT chips per bit.
module chip_timer
    import rep_code_pkg::*;
#(
    parameter int REPEAT        = DEFAULT_REPEAT,
    parameter int CLKS_PER_CHIP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int CLK_W  = $clog2(CLKS_PER_CHIP) + 1;
    localparam int CHIP_W = $clog2(REPEAT) + 1;

    logic [CLK_W-1:0]  clk_cnt;
    logic [CHIP_W-1:0] chip_cnt;
    logic              clk_wrap;
    logic              chip_last;

    assign clk_wrap  = (clk_cnt == CLK_W'(CLKS_PER_CHIP - 1));
    assign chip_last = (chip_cnt == CHIP_W'(REPEAT - 1));
    assign bit_tick  = run & clk_wrap & chip_last;

    // Holding the counters at zero while idle keeps every frame aligned to its accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            clk_cnt  <= '0;
            chip_cnt <= '0;
        end else if (clk_wrap) begin
            clk_cnt  <= '0;
            chip_cnt <= chip_last ? '0 : chip_cnt + CHIP_W'(1);
        end else begin
            clk_cnt  <= clk_cnt + CLK_W'(1);
        end
    end

endmodule

// File: rtl/repetition_code_tx.sv
// Repetition-coded UART-style transmitter: start, DATA_W bits LSB-first, stop; each bit sent REPEAT times.
module repetition_code_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int REPEAT        = DEFAULT_REPEAT,
    parameter int CLKS_PER_CHIP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        fsm_state
);

    // Handshake: a word is taken on any rising edge where valid_in & ready_out; ready_out is high only in IDLE.

    if (DATA_W < 1 || REPEAT < 1 || CLKS_PER_CHIP < 1 || (REPEAT % 2) == 0) begin : g_bad_params
        $error("repetition_code_tx: DATA_W, REPEAT, CLKS_PER_CHIP must be >= 1 and REPEAT odd");
    end

    localparam int BIT_W = $clog2(DATA_W) + 1;

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic              bit_tick;
    logic              accept;

    assign ready_out  = (state == S_IDLE);
    assign busy       = ~ready_out;
    assign accept     = valid_in & ready_out;
    assign frame_done = (state == S_STOP) & bit_tick;
    assign fsm_state  = state;
    assign shreg_next = shreg >> 1;

    chip_timer #(
        .REPEAT        (REPEAT),
        .CLKS_PER_CHIP (CLKS_PER_CHIP)
    ) u_chip_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (busy),
        .bit_tick (bit_tick)
    );

    // tx_out is loaded with the value of the state being entered, so the line follows the FSM by zero cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx_out  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg   <= data_in;
                        bit_cnt <= '0;
                        state   <= S_START;
                        tx_out  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_tick) begin
                        state  <= S_DATA;
                        tx_out <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        shreg <= shreg_next;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_STOP;
                            tx_out  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx_out  <= shreg_next[0];
                        end
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        state  <= S_IDLE;
                        tx_out <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repetition_code_tx.sv
// Directed and randomized checks of repetition_code_tx against a per-cycle line model and a majority-vote receiver model.
module tb_repetition_code_tx;
    import rep_code_pkg::*;

    localparam int DATA_W  = 8;
    localparam int REP     = 5;
    localparam int CPC     = 4;
    localparam int BIT_LEN = REP * CPC;
    localparam int FRAME   = frame_cycles(DATA_W, REP, CPC);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              tx_out;
    logic              busy;
    logic              frame_done;
    logic [1:0]        fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              smp[FRAME];
    logic [DATA_W-1:0] got;
    logic              start_v;
    logic              stop_v;
    int                ones;
    int                flip;
    logic              v;

    repetition_code_tx #(
        .DATA_W        (DATA_W),
        .REPEAT        (REP),
        .CLKS_PER_CHIP (CPC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles into a frame: bit slot 0 is start, last slot is stop.
    function automatic logic line_model(input logic [DATA_W-1:0] word, input int k);
        int slot;
        slot = k / BIT_LEN;
        if (slot == 0) return 1'b0;
        if (slot == DATA_W + 1) return 1'b1;
        return word[slot - 1];
    endfunction

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check1({tag, " idle tx"}, tx_out, 1'b1);
            check1({tag, " idle ready"}, ready_out, 1'b1);
            check1({tag, " idle done"}, frame_done, 1'b0);
            tick();
        end
    endtask

    task automatic accept(input logic [DATA_W-1:0] word);
        data_in  = word;
        valid_in = 1'b1;
        check1("accept ready", ready_out, 1'b1);
        tick();
    endtask

    // Called in the first cycle after the accept edge; returns in the cycle after the frame (or after an abort).
    task automatic frame_check(input logic [DATA_W-1:0] word, input int abort_at, input int pulse_at,
                               input logic hold_valid, input logic [DATA_W-1:0] next_data);
        string tag;
        logic  aborted;
        aborted = 1'b0;
        tag = $sformatf("frame %02h", word);
        for (int k = 1; k <= FRAME && !aborted; k++) begin
            check1({tag, " tx"}, tx_out, line_model(word, k - 1));
            check1({tag, " done"}, frame_done, k == FRAME);
            check1({tag, " ready"}, ready_out, 1'b0);
            check1({tag, " busy"}, busy, 1'b1);
            if (k == 1) begin
                data_in  = next_data;
                valid_in = hold_valid;
            end
            if (k == pulse_at) begin
                data_in  = 8'h3C;
                valid_in = 1'b1;
            end
            if (k == pulse_at + 1) valid_in = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                check1({tag, " abort tx"}, tx_out, 1'b1);
                check1({tag, " abort ready"}, ready_out, 1'b1);
                check1({tag, " abort done"}, frame_done, 1'b0);
                check1({tag, " abort busy"}, busy, 1'b0);
                aborted = 1'b1;
            end else begin
                tick();
            end
        end
        if (!aborted) begin
            check1({tag, " after tx"}, tx_out, 1'b1);
            check1({tag, " after ready"}, ready_out, 1'b1);
            check1({tag, " after done"}, frame_done, 1'b0);
            check1({tag, " after busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        // Step 1: reset held with valid_in high; no frame may start.
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = DATA_W'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("reset tx", tx_out, 1'b1);
            check1("reset ready", ready_out, 1'b1);
            check1("reset done", frame_done, 1'b0);
            check1("reset busy", busy, 1'b0);
        end
        valid_in = 1'b0;
        rst_n    = 1'b1;
        tick();
        check_idle("post reset", 5);

        // Step 2: single 8'hA5 frame.
        accept(8'hA5);
        frame_check(8'hA5, -1, -1, 1'b0, DATA_W'($urandom));
        check_idle("after A5", 3);

        // Step 3: back-to-back 00 then FF with valid_in held high.
        accept(8'h00);
        frame_check(8'h00, -1, -1, 1'b1, 8'hFF);
        tick();
        frame_check(8'hFF, -1, -1, 1'b0, DATA_W'($urandom));
        check_idle("after FF", 3);

        // Step 4: a request while busy is dropped.
        accept(8'hA5);
        frame_check(8'hA5, -1, 50, 1'b0, DATA_W'($urandom));
        check_idle("after ignored 3C", FRAME + 10);

        // Step 5: mid-frame reset, then a clean frame.
        accept(8'h0F);
        frame_check(8'h0F, 90, -1, 1'b0, DATA_W'($urandom));
        check_idle("after abort", FRAME);
        accept(8'h81);
        frame_check(8'h81, -1, -1, 1'b0, DATA_W'($urandom));

        // Step 6: loopback through a majority-of-REP voter with one chip per bit inverted.
        for (int w = 0; w < 256; w++) begin
            exp_q.push_back(w[DATA_W-1:0]);
            accept(w[DATA_W-1:0]);
            valid_in = 1'b0;
            data_in  = DATA_W'($urandom);
            for (int k = 0; k < FRAME; k++) begin
                smp[k] = tx_out;
                tick();
            end
            got     = '0;
            start_v = 1'b1;
            stop_v  = 1'b0;
            for (int g = 0; g < DATA_W + 2; g++) begin
                ones = 0;
                flip = int'($urandom_range(0, REP - 1));
                for (int c = 0; c < REP; c++) begin
                    v = smp[g * BIT_LEN + c * CPC + CPC / 2];
                    if (c == flip) v = ~v;
                    if (v) ones++;
                end
                if (g == 0) start_v = (ones > REP / 2);
                else if (g == DATA_W + 1) stop_v = (ones > REP / 2);
                else got[g - 1] = (ones > REP / 2);
            end
            check1("loopback start", start_v, 1'b0);
            check1("loopback stop", stop_v, 1'b1);
            check8("loopback word", got, exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
